// File: rtl/noc_rr_aggregator.sv
// noc_rr_aggregator
// Merges CPU_NB independent valid/ready ingress streams onto a single egress
// stream. Each channel is buffered in its own DEPTH-entry FIFO, and a
// round-robin arbiter selects which non-empty FIFO feeds the single-stage
// output register. Every output beat is tagged with its source channel, and
// each channel keeps a saturating count of beats accepted downstream.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_vld    per-channel valid
//   in_rdy    per-channel ready (FIFO not full, low during reset)
//   in_data   per-channel payload, channel i at [i*DATA_W +: DATA_W]
//   out_vld   merged-stream valid
//   out_rdy   merged-stream ready from the consumer
//   out_data  merged payload
//   out_src   source channel of the current output beat
//   beat_cnt  per-channel accepted-beat counters, channel i at [i*CNT_W +: CNT_W]
module noc_rr_aggregator #(
   parameter int  CPU_NB = 4,
   parameter int  DATA_W = 64,
   parameter int  DEPTH  = 4,
   parameter int  CNT_W  = 16,
   localparam int SRC_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CPU_NB-1:0]          in_vld,
   output logic [CPU_NB-1:0]          in_rdy,
   input  logic [CPU_NB*DATA_W-1:0]   in_data,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [DATA_W-1:0]          out_data,
   output logic [SRC_W-1:0]           out_src,
   output logic [CPU_NB*CNT_W-1:0]    beat_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem    [CPU_NB][DEPTH];
   logic [AW:0]       wr_ptr [CPU_NB];
   logic [AW:0]       rd_ptr [CPU_NB];
   logic [CNT_W-1:0]  cnt    [CPU_NB];

   logic [CPU_NB-1:0] full;
   logic [CPU_NB-1:0] empty;
   logic [CPU_NB-1:0] push;
   logic [CPU_NB-1:0] pop;

   logic [SRC_W-1:0]  rr_ptr;
   logic [SRC_W-1:0]  gnt_idx;
   logic [SRC_W-1:0]  cand;
   logic              gnt_vld;
   logic              load;

   for (genvar i = 0; i < CPU_NB; i++) begin : g_ch
      // Extra pointer MSB distinguishes full from empty when the index bits match.
      assign empty[i] = (wr_ptr[i] == rd_ptr[i]);
      assign full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                        (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      // Ready depends only on occupancy; a full FIFO stays not-ready even
      // in the cycle it is popped.
      assign in_rdy[i] = !rst && !full[i];
      assign push[i]   = in_vld[i] && in_rdy[i];
      assign pop[i]    = load && (gnt_idx == SRC_W'(i));
      assign beat_cnt[i*CNT_W +: CNT_W] = cnt[i];
   end

   // First non-empty channel found scanning upward from the pointer, wrapping.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < CPU_NB; k++) begin
         cand = SRC_W'((int'(rr_ptr) + k) % CPU_NB);
         if (!gnt_vld && !empty[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign load = (!out_vld || out_rdy) && gnt_vld;

   // Storage has no reset; emptiness is defined by the pointers alone.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CPU_NB; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i][AW-1:0]] <= in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CPU_NB; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
         out_vld  <= 1'b0;
         out_data <= '0;
         out_src  <= '0;
         rr_ptr   <= '0;
      end else begin
         for (int i = 0; i < CPU_NB; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= wr_ptr[i] + 1'b1;
            end
            if (pop[i]) begin
               rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
            if (out_vld && out_rdy && (out_src == SRC_W'(i)) && (cnt[i] != '1)) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end

         if (load) begin
            out_vld  <= 1'b1;
            out_data <= mem[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
            out_src  <= gnt_idx;
            rr_ptr   <= (gnt_idx == SRC_W'(CPU_NB - 1)) ? '0 : gnt_idx + 1'b1;
         end else if (out_rdy) begin
            out_vld  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_noc_rr_aggregator.sv
// Self-checking bench for noc_rr_aggregator (CPU_NB=4, DEPTH=4, DATA_W=64).
// A second instance with CNT_W=4 shares the stimulus and is held in reset
// until the counter saturation scenario.
module tb_noc_rr_aggregator;

   localparam int N     = 4;
   localparam int DW    = 64;
   localparam int DEP   = 4;
   localparam int CW    = 16;
   localparam int CMAX  = 65535;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            rst_sat = 1'b1;
   logic [N-1:0]    in_vld = '0;
   logic [N-1:0]    in_rdy;
   logic [N*DW-1:0] in_data = '0;
   logic            out_vld;
   logic            out_rdy = 1'b1;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_src;
   logic [N*CW-1:0] beat_cnt;

   logic [N-1:0]    sat_in_rdy;
   logic            sat_out_vld;
   logic [DW-1:0]   sat_out_data;
   logic [1:0]      sat_out_src;
   logic [N*4-1:0]  sat_beat_cnt;

   always #5 clk = ~clk;

   noc_rr_aggregator #(.CPU_NB(N), .DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_src(out_src),
      .beat_cnt(beat_cnt));

   noc_rr_aggregator #(.CPU_NB(N), .DATA_W(DW), .DEPTH(DEP), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst_sat), .in_vld(in_vld), .in_rdy(sat_in_rdy), .in_data(in_data),
      .out_vld(sat_out_vld), .out_rdy(out_rdy), .out_data(sat_out_data),
      .out_src(sat_out_src), .beat_cnt(sat_beat_cnt));

   int checks = 0;
   int failures = 0;

   // Reference model: per-channel queues, a round-robin pointer, one output slot.
   logic [DW-1:0] mq [N][$];
   int            m_ptr = 0;
   bit            m_out_vld = 0;
   logic [DW-1:0] m_out_data = '0;
   int            m_out_src = 0;
   int            m_cnt [N];
   bit            m_pushed [N];

   int            to_send [N];
   int            seq [N];
   int            log_src [$];
   logic [DW-1:0] log_data [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pay(input int ch, input int s);
      return {16'hA5A5, 16'(ch), 32'(s)};
   endfunction

   task automatic model_step();
      bit rdy [N];
      int g;
      for (int i = 0; i < N; i++) begin
         rdy[i] = !rst && (mq[i].size() < DEP);
         m_pushed[i] = 0;
      end
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_cnt[i] = 0;
         end
         m_ptr = 0; m_out_vld = 0; m_out_data = '0; m_out_src = 0;
      end else begin
         if (m_out_vld && out_rdy && m_cnt[m_out_src] < CMAX) m_cnt[m_out_src]++;
         if (!m_out_vld || out_rdy) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
               if (g < 0 && mq[(m_ptr + k) % N].size() > 0) g = (m_ptr + k) % N;
            end
            if (g >= 0) begin
               m_out_data = mq[g].pop_front();
               m_out_src  = g;
               m_out_vld  = 1;
               m_ptr      = (g + 1) % N;
            end else begin
               m_out_vld  = 0;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (in_vld[i] && rdy[i]) begin
               mq[i].push_back(in_data[i*DW +: DW]);
               m_pushed[i] = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [N-1:0]    exp_rdy;
      logic [N*CW-1:0] exp_cnt;
      for (int i = 0; i < N; i++) begin
         exp_rdy[i] = !rst && (mq[i].size() < DEP);
         exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
      end
      chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      chk("out_vld", 64'(out_vld), 64'(m_out_vld));
      if (m_out_vld) begin
         chk("out_data", out_data, m_out_data);
         chk("out_src", 64'(out_src), 64'(m_out_src));
      end
      chk("beat_cnt", beat_cnt, exp_cnt);
   endtask

   // One clock: model advances on the inputs the DUT sees at this edge,
   // outputs are compared at the following falling edge.
   task automatic tick();
      bit            hold;
      logic [DW-1:0] hd;
      logic [1:0]    hs;
      model_step();
      if (out_vld && out_rdy && !rst) begin
         log_src.push_back(int'(out_src));
         log_data.push_back(out_data);
      end
      hold = out_vld && !out_rdy && !rst;
      hd = out_data;
      hs = out_src;
      @(posedge clk);
      @(negedge clk);
      check_all();
      if (hold) begin
         chk("hold_data", out_data, hd);
         chk("hold_src", 64'(out_src), 64'(hs));
      end
   endtask

   task automatic start_scn();
      in_vld = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         to_send[i] = 0;
         seq[i] = 0;
      end
      log_src.delete();
      log_data.delete();
   endtask

   function automatic bit busy();
      bit b = m_out_vld;
      for (int i = 0; i < N; i++) if (to_send[i] > 0 || mq[i].size() > 0) b = 1;
      return b;
   endfunction

   task automatic drive(input int max_cyc, input int rdy_pct, input bit rand_vld);
      int n = 0;
      while (busy() && n < max_cyc) begin
         for (int i = 0; i < N; i++) begin
            in_vld[i] = (to_send[i] > 0) && (!rand_vld || ($urandom_range(1) == 1));
            in_data[i*DW +: DW] = pay(i, seq[i]);
         end
         out_rdy = ($urandom_range(99) < rdy_pct);
         tick();
         for (int i = 0; i < N; i++) begin
            if (m_pushed[i]) begin
               seq[i]++;
               to_send[i]--;
            end
         end
         n++;
      end
      in_vld = '0;
      out_rdy = 1'b1;
      chk("drive_within_budget", 64'(n < max_cyc), 64'd1);
   endtask

   task automatic check_log(input string tag, input int n_exp);
      int es [N];
      for (int i = 0; i < N; i++) es[i] = 0;
      chk(tag, 64'(log_src.size()), 64'(n_exp));
      for (int j = 0; j < log_src.size(); j++) begin
         chk(tag, log_data[j], pay(log_src[j], es[log_src[j]]));
         es[log_src[j]]++;
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      @(negedge clk);

      // Reset state
      #1 chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      tick();
      tick();
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_src", 64'(out_src), 64'd0);
      chk("rst_beat_cnt", beat_cnt, 64'd0);

      // 1. Single-beat latency from channel 2
      start_scn();
      out_rdy = 1'b1;
      in_vld = 4'b0100;
      in_data[2*DW +: DW] = 64'hDEAD_BEEF_0000_0002;
      tick();
      in_vld = '0;
      chk("lat_not_yet", 64'(out_vld), 64'd0);
      tick();
      chk("lat_vld", 64'(out_vld), 64'd1);
      chk("lat_data", out_data, 64'hDEAD_BEEF_0000_0002);
      chk("lat_src", 64'(out_src), 64'd2);
      tick();
      chk("lat_cnt", beat_cnt, 64'h0000_0001_0000_0000);
      chk("lat_drained", 64'(out_vld), 64'd0);

      // 2. Round-robin fairness, all channels busy
      start_scn();
      for (int i = 0; i < N; i++) to_send[i] = 8;
      drive(200, 100, 0);
      check_log("rr_order", 32);
      for (int j = 0; j < log_src.size(); j++) chk("rr_src_seq", 64'(log_src[j]), 64'(j % N));
      chk("rr_cnt", beat_cnt, {4{16'd8}});

      // 3. Backpressure and full FIFO
      start_scn();
      out_rdy = 1'b0;
      for (int c = 0; c < 8; c++) begin
         in_vld = 4'b0001;
         in_data[0 +: DW] = pay(0, seq[0]);
         tick();
         if (m_pushed[0]) seq[0]++;
      end
      chk("bp_full_rdy", 64'(in_rdy[0]), 64'd0);
      chk("bp_held_data", out_data, pay(0, 0));
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      chk("bp_rdy_back", 64'(in_rdy[0]), 64'd1);
      chk("bp_next_data", out_data, pay(0, 1));
      to_send[0] = 20 - seq[0];
      drive(600, 50, 1);
      check_log("bp_order", 20);

      // 4. Only channels 1 and 3 active
      start_scn();
      to_send[1] = 4;
      to_send[3] = 4;
      drive(100, 100, 0);
      check_log("skip_order", 8);
      for (int j = 0; j < log_src.size(); j++)
         chk("skip_src", 64'(log_src[j]), (j % 2 == 0) ? 64'd1 : 64'd3);

      // 5. Reset with beats buffered and the output valid
      start_scn();
      to_send[1] = 2;
      drive(50, 100, 0);
      chk("mid_cnt_pre", beat_cnt, 64'h0000_0000_0002_0000);
      out_rdy = 1'b0;
      to_send[0] = 4;
      to_send[3] = 2;
      for (int c = 0; c < 12 && (to_send[0] > 0 || to_send[3] > 0); c++) begin
         for (int i = 0; i < N; i++) begin
            in_vld[i] = to_send[i] > 0;
            in_data[i*DW +: DW] = pay(i, seq[i]);
         end
         tick();
         for (int i = 0; i < N; i++) if (m_pushed[i]) begin seq[i]++; to_send[i]--; end
      end
      in_vld = '0;
      chk("mid_vld_pre", 64'(out_vld), 64'd1);
      rst = 1'b1;
      #1 chk("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
      tick();
      chk("mid_vld_post", 64'(out_vld), 64'd0);
      chk("mid_cnt_post", beat_cnt, 64'd0);
      rst = 1'b0;
      out_rdy = 1'b1;
      log_src.delete();
      log_data.delete();
      repeat (6) tick();
      chk("mid_no_stale", 64'(log_src.size()), 64'd0);

      // 6. Counter saturation on the CNT_W=4 instance
      rst_sat = 1'b1;
      start_scn();
      rst_sat = 1'b0;
      to_send[1] = 20;
      drive(100, 100, 0);
      chk("sat_main_cnt", 64'(beat_cnt[1*CW +: CW]), 64'd20);
      chk("sat_cnt", 64'(sat_beat_cnt[1*4 +: 4]), 64'd15);
      chk("sat_others", 64'({sat_beat_cnt[15:8], sat_beat_cnt[3:0]}), 64'd0);
      rst_sat = 1'b1;

      // 7. Randomized traffic against the model
      start_scn();
      for (int i = 0; i < N; i++) to_send[i] = $urandom_range(60, 30);
      drive(3000, 60, 1);
      check_log("rand_order", log_src.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
